// File: rtl/code_mem_arbiter.sv
// code_mem_arbiter: two-master bounded-burst round-robin arbiter for the single-port code/data RAM
//   clk, rst (async, active-low)
//   m0_*/m1_* : req/we/addr/wdata in, gnt (combinational), rvalid/rdata out
//   mem_*     : RAM strobe, write enable, address, write data out; read data in (one-cycle latency)
module code_mem_arbiter #(
   parameter int AW        = 12,
   parameter int DW        = 8,
   parameter int BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [1:0] IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2;
   logic [1:0]    state;
   logic          last_owner;
   logic [CW-1:0] cnt;
   logic          rd_pend, rd_src;
   logic          burst, repeat_gnt;
   // Under contention the current owner keeps the port until its burst is used up,
   // after which the master that did not win last time takes over.
   always_comb begin
      burst = (state != IDLE) && (cnt < CW'(BURST_MAX));
      m0_gnt = rst && m0_req && (!m1_req || (burst ? state == OWN0 : last_owner));
      m1_gnt = rst && m1_req && (!m0_req || (burst ? state == OWN1 : !last_owner));
      repeat_gnt = (m0_gnt && state == OWN0) || (m1_gnt && state == OWN1);
   end
   assign mem_en    = m0_gnt | m1_gnt;
   assign mem_we    = m0_gnt ? m0_we : m1_gnt & m1_we;
   assign mem_addr  = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
   assign mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
   assign m0_rvalid = rd_pend & ~rd_src;
   assign m1_rvalid = rd_pend & rd_src;
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         cnt        <= '0;
         rd_pend    <= 1'b0;
         rd_src     <= 1'b0;
      end else begin
         state <= m0_gnt ? OWN0 : m1_gnt ? OWN1 : IDLE;
         if (mem_en) last_owner <= m1_gnt;
         cnt <= !mem_en ? '0 :
                repeat_gnt ? (cnt == CW'(BURST_MAX) ? cnt : cnt + CW'(1)) : CW'(1);
         rd_pend <= (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
         rd_src  <= m1_gnt;
      end
   end
endmodule

// File: tb/tb_code_mem_arbiter.sv
// tb_code_mem_arbiter: self-checking bench for code_mem_arbiter with a history-based policy model
module tb_code_mem_arbiter;
   localparam int BURST = 4;
   logic clk = 1'b0, rst = 1'b0;
   logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [11:0] m0_addr = 0, m1_addr = 0;
   logic [7:0] m0_wdata = 0, m1_wdata = 0;
   logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
   logic [7:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
   logic [11:0] mem_addr;
   logic b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we;
   logic [7:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
   logic [11:0] b_mem_addr;
   logic pre_we = 0;
   logic [11:0] pre_addr = 0;
   logic [7:0] pre_data = 0;
   logic [7:0] ram [0:4095];
   logic [7:0] sh [0:4095];
   int hist[$];
   logic pend_v = 0, pend_src = 0;
   logic [7:0] pend_data = 0;
   int exp_g;
   logic exp_rv0, exp_rv1;
   logic [7:0] exp_rd;
   int total = 0, bad = 0;

   code_mem_arbiter #(.AW(12), .DW(8), .BURST_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));

   code_mem_arbiter #(.AW(12), .DW(8), .BURST_MAX(1)) dut_alt (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(8'h00));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else mem_rdata <= ram[mem_addr];
      end
   end

   // Policy from the grant history: a master keeps winning contention while its trailing
   // run of grants is shorter than BURST; otherwise whoever did not win most recently wins.
   function automatic int ref_grant(logic r0, logic r1);
      int last = 1;
      int run = 0;
      int n = hist.size();
      if (!r0 && !r1) return -1;
      if (r0 != r1) return r0 ? 0 : 1;
      for (int i = n - 1; i >= 0; i--) if (hist[i] >= 0) begin last = hist[i]; break; end
      if (n > 0 && hist[n-1] >= 0) begin
         for (int i = n - 1; i >= 0 && hist[i] == hist[n-1]; i--) run++;
         if (run < BURST) return hist[n-1];
      end
      return 1 - last;
   endfunction

   task automatic drive(input logic rs, input logic r0, input logic w0, input logic [11:0] a0,
                        input logic [7:0] d0, input logic r1, input logic w1,
                        input logic [11:0] a1, input logic [7:0] d1);
      @(negedge clk);
      rst = rs; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      #1;
      if (!rs) begin
         hist.delete(); pend_v = 0; exp_g = -1; exp_rv0 = 0; exp_rv1 = 0; exp_rd = 0;
      end else begin
         exp_rv0 = pend_v && !pend_src;
         exp_rv1 = pend_v && pend_src;
         exp_rd = pend_data;
         exp_g = ref_grant(r0, r1);
         hist.push_back(exp_g);
         pend_v = 0;
         if (exp_g == 0) begin
            pend_v = !w0; pend_src = 0; pend_data = sh[a0];
            if (w0) sh[a0] = d0;
         end else if (exp_g == 1) begin
            pend_v = !w1; pend_src = 1; pend_data = sh[a1];
            if (w1) sh[a1] = d1;
         end
      end
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      idle();
      pre_we = 1; pre_addr = a; pre_data = d; sh[a] = d;
      idle();
      pre_we = 0;
   endtask

   task automatic test_reset();
      drive(0, 1, 0, 12'h005, 0, 1, 0, 12'h007, 0);
      total++; if (m0_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt0 got=%b exp=0", m0_gnt); end
      total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt1 got=%b exp=0", m1_gnt); end
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
      idle();
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_rel_mem_en got=%b exp=0", mem_en); end
   endtask

   task automatic test_single_read();
      preload(12'h006, 8'h0A);
      drive(1, 1, 0, 12'h006, 0, 0, 0, 0, 0);
      total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL sr_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
      total++; if ({mem_en, mem_we} !== 2'b10) begin bad++; $display("FAIL sr_en_we got=%b exp=10", {mem_en, mem_we}); end
      total++; if (mem_addr !== 12'h006) begin bad++; $display("FAIL sr_addr got=%h exp=006", mem_addr); end
      idle();
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin bad++; $display("FAIL sr_rvalid got=%b exp=10", {m0_rvalid, m1_rvalid}); end
      total++; if (m0_rdata !== 8'h0A) begin bad++; $display("FAIL sr_rdata got=%h exp=0a", m0_rdata); end
      total++; if (m1_rdata !== 8'h00) begin bad++; $display("FAIL sr_rdata1 got=%h exp=00", m1_rdata); end
      idle();
      total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL sr_rvalid_once got=%b exp=0", m0_rvalid); end
   endtask

   task automatic test_alternate();
      int e1[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         drive(1, 1, 0, 12'h001, 0, 1, 0, 12'h002, 0);
         total++; if ({m0_gnt, m1_gnt} !== {e1[i] == 0, e1[i] == 1}) begin bad++; $display("FAIL alt_b4 cyc=%0d got=%b exp_m1=%0d", i, {m0_gnt, m1_gnt}, e1[i]); end
         total++; if ({b_m0_gnt, b_m1_gnt} !== {i % 2 == 0, i % 2 == 1}) begin bad++; $display("FAIL alt_b1 cyc=%0d got=%b exp_m1=%0d", i, {b_m0_gnt, b_m1_gnt}, i % 2); end
         total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL alt_no_idle cyc=%0d got=%b exp=1", i, mem_en); end
      end
   endtask

   task automatic test_write_readback();
      idle();
      drive(1, 0, 0, 0, 0, 1, 1, 12'h000, 8'h78);
      total++; if ({m1_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h000, 8'h78}) begin bad++; $display("FAIL wr0 got=%b%b %h %h exp=11 000 78", m1_gnt, mem_we, mem_addr, mem_wdata); end
      drive(1, 0, 0, 0, 0, 1, 1, 12'h001, 8'h02);
      total++; if ({m1_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h001, 8'h02}) begin bad++; $display("FAIL wr1 got=%b%b %h %h exp=11 001 02", m1_gnt, mem_we, mem_addr, mem_wdata); end
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid0 got=%b exp=00", {m0_rvalid, m1_rvalid}); end
      drive(1, 1, 0, 12'h000, 0, 0, 0, 0, 0);
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid1 got=%b exp=00", {m0_rvalid, m1_rvalid}); end
      drive(1, 1, 0, 12'h001, 0, 0, 0, 0, 0);
      total++; if ({m0_gnt, m0_rvalid, m0_rdata} !== {2'b11, 8'h78}) begin bad++; $display("FAIL rb0 got=%b%b %h exp=11 78", m0_gnt, m0_rvalid, m0_rdata); end
      idle();
      total++; if ({m0_rvalid, m0_rdata} !== {1'b1, 8'h02}) begin bad++; $display("FAIL rb1 got=%b %h exp=1 02", m0_rvalid, m0_rdata); end
      idle();
      total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL rb_end got=%b exp=0", m0_rvalid); end
   endtask

   task automatic test_drop();
      int e1[6] = '{0, 1, 1, 1, 1, 0};
      idle();
      drive(1, 1, 0, 12'h002, 0, 0, 0, 0, 0);
      total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL drop_start got=%b exp=1", m0_gnt); end
      for (int i = 0; i < 6; i++) begin
         drive(1, i != 1, 0, 12'h003, 0, 1, 0, 12'h004, 0);
         total++; if ({m0_gnt, m1_gnt} !== {e1[i] == 0, e1[i] == 1}) begin bad++; $display("FAIL drop cyc=%0d got=%b exp_m1=%0d", i, {m0_gnt, m1_gnt}, e1[i]); end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      idle();
      drive(1, 1, 0, 12'h003, 0, 0, 0, 0, 0);
      total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt got=%b exp=1", m0_gnt); end
      drive(0, 1, 0, 12'h003, 0, 1, 0, 12'h004, 0);
      total++; if ({m0_gnt, m1_gnt, mem_en} !== 3'b000) begin bad++; $display("FAIL rm_gnt_off got=%b exp=000", {m0_gnt, m1_gnt, mem_en}); end
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rm_rvalid_off got=%b exp=00", {m0_rvalid, m1_rvalid}); end
      drive(1, 1, 0, 12'h003, 0, 1, 0, 12'h004, 0);
      total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL rm_first got=%b exp=10", {m0_gnt, m1_gnt}); end
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rm_stale got=%b exp=00", {m0_rvalid, m1_rvalid}); end
      idle();
   endtask

   task automatic test_random();
      logic q0 = 0, q1 = 0, w0 = 0, w1 = 0;
      logic [11:0] a0 = 0, a1 = 0;
      logic [7:0] d0 = 0, d1 = 0;
      int nbad = bad;
      for (int i = 0; i < 16; i++) preload(12'(i), 8'($urandom));
      for (int i = 0; i < 400; i++) begin
         if (!q0 && $urandom_range(0, 3) != 0) begin q0 = 1; w0 = 1'($urandom); a0 = 12'($urandom_range(0, 15)); d0 = 8'($urandom); end
         if (!q1 && $urandom_range(0, 3) != 0) begin q1 = 1; w1 = 1'($urandom); a1 = 12'($urandom_range(0, 15)); d1 = 8'($urandom); end
         drive(1, q0, w0, a0, d0, q1, w1, a1, d1);
         total++; if ({m0_gnt, m1_gnt, mem_en} !== {exp_g == 0, exp_g == 1, exp_g >= 0}) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp_g=%0d", i, {m0_gnt, m1_gnt, mem_en}, exp_g); end
         total++; if ({mem_we, mem_addr, mem_wdata} !== (exp_g == 0 ? {w0, a0, d0} : exp_g == 1 ? {w1, a1, d1} : 21'h0)) begin bad++; $display("FAIL rnd_mem cyc=%0d got=%b %h %h", i, mem_we, mem_addr, mem_wdata); end
         total++; if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", i, {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1}); end
         total++; if ({m0_rdata, m1_rdata} !== {exp_rv0 ? exp_rd : 8'h00, exp_rv1 ? exp_rd : 8'h00}) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h %h exp=%h", i, m0_rdata, m1_rdata, exp_rd); end
         if (exp_g == 0) q0 = 0;
         if (exp_g == 1) q1 = 0;
         if (bad - nbad > 10) break;
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_alternate();
      test_write_readback();
      test_drop();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/code_mem_arbiter.md
Name: code_mem_arbiter

Overview:
Two-master arbiter for the single-port synchronous code/data RAM of the 8051 core. Master 0 is the core fetch/operand path; master 1 is the program loader/debug port that writes test programs into memory. The block grants one access per cycle and enforces a bounded-burst round-robin policy so neither side starves. It routes read data back to the master that issued the read.

Parameters:
AW, 12, address width (4096-entry code memory)
DW, 8, data width
BURST_MAX, 4, max consecutive grants to one master while the other is requesting (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 access request, held until granted
m0_we  in  1  master 0 write (1) / read (0)
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_gnt  out  1  master 0 granted this cycle (combinational)
m0_rvalid  out  1  master 0 read data valid
m0_rdata  out  DW  master 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as master 0, for master 1
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid one cycle after a read strobe

Behaviour:
- Transfer happens on a cycle where mX_req && mX_gnt. Requester keeps addr/we/wdata stable until granted. At most one gnt per cycle.
- State machine (registered owner of previous cycle): IDLE (no grant last cycle), OWN0, OWN1. Next state = OWN0/OWN1 if that master is granted this cycle, else IDLE.
- last_owner reg (reset 1, so m0 wins the first contention). Updated on every grant.
- cnt: consecutive grants to current owner, reset 0. Increments on a repeat grant to the same owner (saturates at BURST_MAX). Loads 1 on a grant to a new owner. Clears to 0 in IDLE.
- Decision, combinational each cycle:
  - Only one req -> grant it, regardless of cnt.
  - Both req, state OWNx and cnt < BURST_MAX -> grant x (burst continuation).
  - Both req otherwise -> grant the master != last_owner.
  - No req -> no grant.
- BURST_MAX=1 gives strict alternation under continuous contention.
- mem_en = m0_gnt | m1_gnt. mem_we/addr/wdata are muxed from the granted master. When there is no grant, mem_we=0 and addr/wdata=0.
- Read return:
  - Registered rd_pend and rd_src capture a granted read.
  - The next cycle raises mX_rvalid for exactly one cycle for the source master.
  - mX_rdata = mem_rdata when that master's rvalid is high, else 0.
  - Writes never raise rvalid.
- Back-to-back reads: the next read may be granted in the same cycle its predecessor's rvalid is high. Throughput is one access per cycle.
- A master dropping req mid-burst ends the burst. If the other master is requesting, it wins next cycle. If neither is requesting, the state goes IDLE and cnt=0.
- Reset (rst=0, async): state=IDLE, last_owner=1, cnt=0, rd_pend=0, both rvalid=0. gnt and mem_en are forced 0 while rst is low. A read in flight at reset is discarded (no rvalid after release).
- First cycle after rst rises: normal arbitration, no glitch grant.

Test Plan:
- m0 read addr 0x006 alone, RAM holds 0x0A -> m0_gnt same cycle, mem_en=1, mem_we=0; next cycle m0_rvalid=1, m0_rdata=0x0A, m1_rvalid=0.
- Both req continuously from reset, BURST_MAX=4 -> grant order 0,0,0,0,1,1,1,1,0,... with no idle cycles.
- BURST_MAX=1, both req continuously -> grants strictly alternate 0,1,0,1; first grant to m0.
- m1 writes 0x78,0x02 to addr 0x000/0x001, then m0 reads 0x000 and 0x001 back-to-back -> m0_rvalid high two consecutive cycles with data 0x78 then 0x02; no rvalid for writes.
- m0 in burst (cnt=2) drops req while m1 is requesting -> m1 granted the next cycle; m0 re-requesting later wins once m1 has had 4 grants.
- Assert rst low one cycle after m0 read grant -> gnt/mem_en/rvalid go 0 immediately; after release no stale rvalid; first contention goes to m0.
